// File: rtl/branch_predictor_ctrl.sv
// Branch prediction table controller: 2^INDEX_BITS two-bit saturating
// counters with fetch lookup, execute update and a multi-cycle clear.
//
// Ports:
//   clk_i, reset_i    clock; async active-high reset
//   pc_f_i            fetch PC for lookup
//   pc_src_pred_f_o   predicted taken for pc_f_i (forced 0 while busy)
//   update_valid_e_i  execute-stage branch resolved this cycle
//   pc_e_i            PC of the resolving branch
//   pc_src_res_e_i    resolved outcome (1 = taken)
//   flush_table_i     clear whole table to weakly-untaken
//   busy_o            clear sequence in progress
//
// Optional feature: define BP_UPDATE_BYPASS_EN to forward a same-index
// update into the same-cycle lookup.

module branch_predictor_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int PC_WIDTH   = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [PC_WIDTH-1:0] pc_f_i,
  output logic                pc_src_pred_f_o,
  input  logic                update_valid_e_i,
  input  logic [PC_WIDTH-1:0] pc_e_i,
  input  logic                pc_src_res_e_i,
  input  logic                flush_table_i,
  output logic                busy_o
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [1:0] WU = 2'b01;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [INDEX_BITS-1:0] clr_idx_q, clr_idx_d;
  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [1:0]            cnt_q [DEPTH];
  logic [1:0]            upd_val;
  logic                  clr_we, upd_we;
  logic                  pred_raw;
  logic                  unused_pc;

  assign idx_f = pc_f_i[INDEX_BITS+1:2];
  assign idx_e = pc_e_i[INDEX_BITS+1:2];

  // Only the index field of either PC matters; aliasing is intended.
  assign unused_pc = ^{pc_f_i, pc_e_i};

  function automatic logic [1:0] sat_next(
    input logic [1:0] c,
    input logic       taken
  );
    if (taken)
      return (c == 2'b11) ? c : c + 2'd1;
    else
      return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign upd_val = sat_next(cnt_q[idx_e], pc_src_res_e_i);

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state logic; a flush in CLEAR restarts from entry 0.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      IDLE: begin
        if (flush_table_i) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        if (flush_table_i) begin
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == '1)
            state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  // Output logic; a same-cycle flush drops the update.
  always_comb begin
    busy_o = (state_q == CLEAR);
    clr_we = busy_o;
    upd_we = !busy_o && !flush_table_i && update_valid_e_i;
  end

  // Counter table
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++)
        cnt_q[i] <= WU;
    end else if (clr_we) begin
      cnt_q[clr_idx_q] <= WU;
    end else if (upd_we) begin
      cnt_q[idx_e] <= upd_val;
    end
  end

  // Lookup
  always_comb begin
    pred_raw = cnt_q[idx_f][1];
`ifdef BP_UPDATE_BYPASS_EN
    if (upd_we && (idx_f == idx_e))
      pred_raw = upd_val[1];
`endif
    pc_src_pred_f_o = pred_raw & ~busy_o;
  end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Scoreboard bench for branch_predictor_ctrl: directed scenarios then
// random traffic against a counter-array reference model.

module tb_branch_predictor_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [31:0] pc_f_i = '0;
  logic        pc_src_pred_f_o;
  logic        update_valid_e_i = 1'b0;
  logic [31:0] pc_e_i = '0;
  logic        pc_src_res_e_i = 1'b0;
  logic        flush_table_i = 1'b0;
  logic        busy_o;

  branch_predictor_ctrl #(.INDEX_BITS(4), .PC_WIDTH(32)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .pc_f_i           (pc_f_i),
    .pc_src_pred_f_o  (pc_src_pred_f_o),
    .update_valid_e_i (update_valid_e_i),
    .pc_e_i           (pc_e_i),
    .pc_src_res_e_i   (pc_src_res_e_i),
    .flush_table_i    (flush_table_i),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic pred;
    logic busy;
    int   tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cycle_no = 0;

`ifdef BP_UPDATE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Reference model: counter values 0..3 and cycles of clearing left.
  int cnt [16];
  int clr_left;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic int bump(input int c, input logic taken);
    if (taken) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    foreach (cnt[i]) cnt[i] = 1;
    clr_left = 0;
  endtask

  task automatic step(
    input logic [31:0] pcf,
    input logic        upd,
    input logic [31:0] pce,
    input logic        res,
    input logic        flush,
    input logic        rst
  );
    exp_t e;
    int   fi, ei;
    @(posedge clk_i);
    #1;
    cycle_no++;
    pc_f_i = pcf;
    update_valid_e_i = upd;
    pc_e_i = pce;
    pc_src_res_e_i = res;
    flush_table_i = flush;
    reset_i = rst;
    fi = idx_of(pcf);
    ei = idx_of(pce);
    if (rst) model_reset();
    e.tag  = cycle_no;
    e.busy = (clr_left > 0);
    if (e.busy)
      e.pred = 1'b0;
    else if (BYPASS && upd && !flush && !rst && fi == ei)
      e.pred = (bump(cnt[ei], res) >= 2);
    else
      e.pred = (cnt[fi] >= 2);
    exp_q.push_back(e);
    if (rst) begin
      // state held in reset across the next edge
    end else if (clr_left > 0) begin
      cnt[16 - clr_left] = 1;
      clr_left = flush ? 16 : clr_left - 1;
    end else if (flush) begin
      clr_left = 16;
    end else if (upd) begin
      cnt[ei] = bump(cnt[ei], res);
    end
  endtask

  task automatic look(input logic [31:0] pcf);
    step(pcf, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pcf, input logic [31:0] pce,
                     input logic res);
    step(pcf, 1'b1, pce, res, 1'b0, 1'b0);
  endtask

  task automatic flush(input logic [31:0] pcf);
    step(pcf, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: compares every presented cycle against the queue head.
  always @(negedge clk_i) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (busy_o === e.busy) passed++;
      else $display("FAIL busy cyc=%0d got=%b exp=%b", e.tag, busy_o, e.busy);
      checks++;
      if (pc_src_pred_f_o === e.pred) passed++;
      else $display("FAIL pred cyc=%0d pc=%h got=%b exp=%b",
                    e.tag, pc_f_i, pc_src_pred_f_o, e.pred);
    end
  end

  initial begin
    model_reset();
    step(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    look(32'h40);
    // saturation at idx 1
    repeat (3) upd(32'h44, 32'h44, 1'b1);
    look(32'h44);
    upd(32'h44, 32'h44, 1'b0);
    look(32'h44);
    repeat (3) upd(32'h44, 32'h44, 1'b0);
    look(32'h44);
    upd(32'h44, 32'h44, 1'b1);
    look(32'h44);
    // aliasing idx 2 / idx 3
    upd(32'h0, 32'h08, 1'b1);
    upd(32'h0, 32'h08, 1'b1);
    look(32'h48);
    look(32'h4C);
    // flush with idx 5 at ST, update issued mid-clear
    repeat (3) upd(32'h0, 32'h14, 1'b1);
    look(32'h14);
    flush(32'h14);
    repeat (5) look(32'h14);
    upd(32'h14, 32'h08, 1'b1);
    repeat (12) look(32'h14);
    look(32'h08);
    upd(32'h14, 32'h14, 1'b1);
    look(32'h14);
    // flush with same-cycle update to idx 4
    step(32'h10, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0);
    repeat (17) look(32'h10);
    // flush re-pulsed at clear cycle 8
    upd(32'h0, 32'h10, 1'b1);
    flush(32'h10);
    repeat (7) look(32'h10);
    flush(32'h10);
    repeat (18) look(32'h10);
    // reset at clear cycle 3
    upd(32'h0, 32'h18, 1'b1);
    flush(32'h18);
    repeat (2) look(32'h18);
    step(32'h18, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    look(32'h18);
    upd(32'h18, 32'h18, 1'b1);
    look(32'h18);
    // bypass at idx 7
    upd(32'h1C, 32'h1C, 1'b1);
    look(32'h1C);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pf, pe;
      int r;
      pf = $urandom & 32'h0000_03FF;
      pe = ($urandom % 3 == 0) ? pf : ($urandom & 32'h0000_03FF);
      r = $urandom_range(0, 199);
      if (r == 0)
        step(pf, 1'b0, pe, 1'b0, 1'b0, 1'b1);
      else
        step(pf, ($urandom % 4) != 0, pe, $urandom % 2,
             r < 5, 1'b0);
    end
    @(posedge clk_i);
    #1;
    pc_f_i = '0;
    update_valid_e_i = 1'b0;
    flush_table_i = 1'b0;
    reset_i = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++)
      @(posedge clk_i);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain left=%0d exp=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_ctrl.md
# branch_predictor_ctrl

Controller for the branch prediction table: a bank of 2^INDEX_BITS two-bit saturating counters. It serves a fetch-stage lookup, applies the execute-stage resolved-outcome update to the selected counter, and runs a multi-cycle clear sequence on request, such as a context switch or a predictor flush. It sits between the fetch PC mux, which consumes `pc_src_pred_f_o`, and the execute-stage branch resolution logic.

## Interface
Parameters:
- `INDEX_BITS`, default 4 — table has 2^INDEX_BITS entries (16 by default).
- `PC_WIDTH`, default 32 — width of PC inputs.

Ports:
- `clk_i` input 1 — clock.
- `reset_i` input 1 — reset, asynchronous, active-high.
- `pc_f_i` input PC_WIDTH — fetch-stage PC used for lookup.
- `pc_src_pred_f_o` output 1 — predicted taken (1) / not taken (0) for `pc_f_i`.
- `update_valid_e_i` input 1 — a branch resolved in execute this cycle.
- `pc_e_i` input PC_WIDTH — PC of the resolving branch.
- `pc_src_res_e_i` input 1 — actual outcome of the resolving branch (1 = taken).
- `flush_table_i` input 1 — request to clear the whole table to weakly-untaken.
- `busy_o` output 1 — a clear sequence is in progress.

## Operation
- Index derivation:
  - Lookup index `idx_f` = `pc_f_i[INDEX_BITS+1:2]`.
  - Update index `idx_e` = `pc_e_i[INDEX_BITS+1:2]`.
  - PC bits [1:0] and bits above INDEX_BITS+1 are ignored, so aliasing is permitted.
- Counter encoding: ST=2'b11, WT=2'b10, WU=2'b01, SU=2'b00. Prediction is the counter MSB.
- Counter update, applied when `update_valid_e_i`=1 in IDLE:
  - Taken: SU→WU→WT→ST, saturating at ST.
  - Not taken: ST→WT→WU→SU, saturating at SU.
  - Only entry `idx_e` changes.
- FSM states: IDLE and CLEAR.
  - IDLE → CLEAR when `flush_table_i`=1. Clear pointer `clr_idx` loads 0.
  - In CLEAR, each cycle writes WU to entry `clr_idx` and increments `clr_idx`.
  - The cycle that writes entry 2^INDEX_BITS−1 transitions to IDLE. `clr_idx` wraps to 0.
  - `flush_table_i`=1 while in CLEAR restarts the sequence: `clr_idx` reloads 0 next cycle and the state stays CLEAR.
- Priority and simultaneous events:
  - `flush_table_i` in IDLE takes priority over a same-cycle update; that update is dropped.
  - Any `update_valid_e_i` during CLEAR is dropped.
  - While `busy_o`=1, `pc_src_pred_f_o` is forced to 0.
- Reset, asynchronous, including mid-clear:
  - All entries go to WU.
  - State goes to IDLE, `clr_idx` to 0, `busy_o` to 0.
  - `pc_src_pred_f_o` therefore reads 0.

## Timing
- Lookup is combinational from `pc_f_i` to `pc_src_pred_f_o` with zero cycles latency. It reads the stored counter value from the start of the cycle unless `BP_UPDATE_BYPASS_EN` is defined.
- An update presented in cycle N is visible to lookups from cycle N+1.
- `busy_o` is registered:
  - It goes high in the cycle after `flush_table_i` is sampled.
  - It stays high for exactly 2^INDEX_BITS cycles (16 by default), then drops.
  - No gap is required between consecutive flushes.
- After `reset_i` deasserts, updates are accepted from the first clock edge.

## Configuration
- `BP_UPDATE_BYPASS_EN` defined:
  - Applies when `update_valid_e_i`=1, `busy_o`=0, `flush_table_i`=0 and `idx_f`==`idx_e`.
  - In that case `pc_src_pred_f_o` is the MSB of the counter's next value, i.e. same-cycle forwarding of the update.
- `BP_UPDATE_BYPASS_EN` undefined: the prediction always comes from the stored counter. A same-index update affects lookups from the next cycle only.
- Table update behaviour is identical in both builds.

## Test plan
- Reset then lookup: reset, `pc_f_i`=0x40 → `pc_src_pred_f_o`=0; entry 0 reads WU.
- Saturation: 3 taken updates at `pc_e_i`=0x44 (idx 1) → entry 1 = ST and prediction for 0x44 = 1. 3 not-taken updates → SU and prediction 0. One further not-taken → stays SU.
- Aliasing: taken, taken at `pc_e_i`=0x08 → lookup `pc_f_i`=0x48 (same idx 2) predicts 1; lookup 0x4C (idx 3) predicts 0.
- Flush sequence: set idx 5 to ST, pulse `flush_table_i` → `busy_o`=1 for 16 cycles and prediction 0 throughout. Afterwards all entries are WU and a taken update at idx 5 yields WT. An update issued mid-clear leaves its entry at WU.
- Simultaneous events:
  - Flush and taken update to idx 4 in the same cycle → idx 4 ends at WU.
  - Flush re-pulsed at clear cycle 8 → `busy_o` stays high 16 more cycles.
  - `reset_i` at clear cycle 3 → `busy_o`=0 immediately and all entries are WU.
- Bypass: idx 7 at WU, taken update and lookup of the same PC in one cycle → prediction 1 with `BP_UPDATE_BYPASS_EN` defined, 0 without it; 1 in both builds on the next cycle.
